joypad_i2c_target: RTL and testbench
====================================

Name: joypad_i2c_target

Overview:
Synthesizable I2C target that answers the game's joypad I2C controller from the device side. It runs as a joypad emulator on a second board or as a bus-accurate model in system simulation. It presents 16 button inputs and an ID byte as readable registers and has one writable LED register. Pin signalling uses open-drain, active-low drive: sda_out=0 pulls SDA low, sda_out=1 releases the line.

Parameters:
- ADDR, 7'h52, 7-bit target address.
- DEVICE_ID, 8'hA5, constant returned by register 2.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, synchronous active-low reset.
- scl_in, input, 1, sampled SCL pin level (asynchronous to clk).
- sda_in, input, 1, sampled SDA pin level (asynchronous to clk).
- sda_out, output, 1, 0 = pull SDA low, 1 = release.
- buttons, input, 16, live button levels, 1 = pressed.
- led, output, 8, register 3 contents.
- busy, output, 1, high from an address-matched ACK until the next STOP or START.

Behaviour:
- Reset (rst_n=0 at a clk edge) puts the block in this state, including mid-transaction:
  - sda_out=1, led=0, busy=0, ptr=0, state IDLE.
  - Synchronizer flops are set to 1.
- Input conditioning:
  - scl_in and sda_in each pass through a 2-flop synchronizer, then a third "previous" flop.
  - scl_rise/scl_fall = synchronized edge of SCL.
  - START = SCL high in both sync and previous samples, and SDA falls.
  - STOP = SCL high in both sync and previous samples, and SDA rises.
  - Requirement on the bus: SCL high and low phases each last at least 4 clk cycles.
- START or STOP detection overrides every state:
  - START: go to ADDR, clear bit counter, set sda_out=1.
  - STOP: go to IDLE, set sda_out=1, busy=0.
- SDA sampling and driving:
  - Bits are sampled on scl_rise.
  - sda_out changes only on scl_fall.
  - Data is MSB first.
- States:
  - IDLE: wait for START.
  - ADDR: shift in 8 bits (7 address bits plus R/W).
    - On the 8th scl_fall: if the address equals ADDR, set sda_out=0 (ACK), busy=1, go to ADDR_ACK.
    - Otherwise go to IGNORE with sda_out=1.
  - ADDR_ACK: on the next scl_fall, release SDA.
    - If R/W=0, go to WR_DATA; first_byte=1.
    - If R/W=1, take a snapshot of {buttons, DEVICE_ID, led} into shadow regs.
    - Then load byte reg[ptr], drive its MSB, go to RD_DATA.
  - WR_DATA: shift in 8 bits; on the 8th scl_fall set sda_out=0 and go to WR_ACK.
    - If first_byte=1, the byte sets ptr to data[1:0]; clear first_byte.
    - Otherwise, if ptr==3, led=data. Then ptr=ptr+1 mod 4.
    - Writes to ptr 0..2 are ACKed and discarded; ptr still increments.
  - WR_ACK: on scl_fall release SDA and return to WR_DATA.
  - RD_DATA: drive bits 6..0 on successive scl_falls. On the 8th scl_fall release SDA, ptr=ptr+1 mod 4, go to RD_ACK.
  - RD_ACK: sample the controller's ACK on scl_rise.
    - ACK (SDA=0): on scl_fall load the shadow byte at ptr and drive its MSB; go to RD_DATA.
    - NACK (SDA=1): go to IGNORE.
  - IGNORE: sda_out=1; wait for START or STOP.
- Register map:
  - 0 = buttons[7:0]
  - 1 = buttons[15:8]
  - 2 = DEVICE_ID
  - 3 = led
  - ptr wraps 3 to 0.
- Read data comes from the snapshot taken at address ACK. Button changes during a burst do not tear the data.
- A repeated START keeps ptr, so a write-pointer-then-read sequence works. STOP also keeps ptr. Only reset clears it.
- General call (address 0) is not supported and is treated as a mismatch.

Test Plan:
- Address 0x52, write {0x03, 0x5A}, STOP → both ACKed; led=0x5A after the 2nd byte's ACK; busy drops at STOP.
- buttons=0xBEEF. Write ptr 0x00, repeated START, read 4 bytes with ACK,ACK,ACK,NACK → data 0xEF, 0xBE, 0xA5, 0x5A; SDA released after the NACK.
- Address 0x53 write → no ACK (SDA high at the 9th clock). Following data bytes are not ACKed. led is unchanged and busy=0 throughout.
- Read starting at ptr=3 for 3 bytes → 0x5A, 0xEF, 0xBE (wrap). buttons change to 0x0000 mid-burst and the returned bytes are unchanged.
- Assert rst_n=0 during RD_DATA while a 0 bit is being driven → next cycle sda_out=1, led=0, busy=0. A fresh START at address 0x52 is ACKed normally.
- Write {0x03} only, STOP, then read 1 byte → 0x5A, confirming ptr persists across STOP.

Source files
------------

// File: rtl/joypad_i2c_target.sv
// I2C target exposing 16 joypad buttons, a device ID and a writable LED register.
// Open-drain SDA: sda_out=0 pulls the line low, 1 releases it.
module joypad_i2c_target #(
  parameter logic [6:0] ADDR      = 7'h52,
  parameter logic [7:0] DEVICE_ID = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_out,
  input  logic [15:0] buttons,
  output logic [7:0]  led,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
  } state_t;

  // [0],[1] form the synchronizer, [2] holds the previous synchronized sample
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], scl_in};
      sda_q <= {sda_q[1:0], sda_in};
    end
  end

  logic scl_s, scl_p, sda_s, sda_p;
  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_s     = scl_q[1];
  assign scl_p     = scl_q[2];
  assign sda_s     = sda_q[1];
  assign sda_p     = sda_q[2];
  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  assign start_det = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_det  = scl_s & scl_p & ~sda_p & sda_s;

  state_t      state_q, state_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  tx_q, tx_d;
  logic        sda_out_q, sda_out_d;
  logic        busy_q, busy_d;
  logic [7:0]  led_q, led_d;
  logic [1:0]  ptr_q, ptr_d;
  logic        first_q, first_d;
  logic        rw_q, rw_d;
  logic        acked_q, acked_d;
  logic [15:0] snap_btn_q, snap_btn_d;
  logic [7:0]  snap_led_q, snap_led_d;

  function automatic logic [7:0] reg_byte(input logic [1:0] p, input logic [15:0] b,
                                          input logic [7:0] l);
    case (p)
      2'd0:    reg_byte = b[7:0];
      2'd1:    reg_byte = b[15:8];
      2'd2:    reg_byte = DEVICE_ID;
      default: reg_byte = l;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    sda_out_d  = sda_out_q;
    busy_d     = busy_q;
    led_d      = led_q;
    ptr_d      = ptr_q;
    first_d    = first_q;
    rw_d       = rw_q;
    acked_d    = acked_q;
    snap_btn_d = snap_btn_q;
    snap_led_d = snap_led_q;

    case (state_q)
      S_ADDR: begin
        if (scl_rise) begin
          shift_d  = {shift_q[6:0], sda_s};
          bitcnt_d = bitcnt_q + 4'd1;
        end else if (scl_fall && bitcnt_q == 4'd8) begin
          // General call (address 0) is deliberately never matched
          if (shift_q[7:1] == ADDR && shift_q[7:1] != 7'd0) begin
            sda_out_d = 1'b0;
            busy_d    = 1'b1;
            rw_d      = shift_q[0];
            state_d   = S_ADDR_ACK;
          end else begin
            sda_out_d = 1'b1;
            state_d   = S_IGNORE;
          end
        end
      end
      S_ADDR_ACK: begin
        if (scl_fall) begin
          sda_out_d = 1'b1;
          bitcnt_d  = 4'd0;
          if (!rw_q) begin
            first_d = 1'b1;
            state_d = S_WR_DATA;
          end else begin
            snap_btn_d = buttons;
            snap_led_d = led_q;
            tx_d       = reg_byte(ptr_q, buttons, led_q);
            sda_out_d  = tx_d[7];
            state_d    = S_RD_DATA;
          end
        end
      end
      S_WR_DATA: begin
        if (scl_rise) begin
          shift_d  = {shift_q[6:0], sda_s};
          bitcnt_d = bitcnt_q + 4'd1;
        end else if (scl_fall && bitcnt_q == 4'd8) begin
          sda_out_d = 1'b0;
          state_d   = S_WR_ACK;
          if (first_q) begin
            ptr_d   = shift_q[1:0];
            first_d = 1'b0;
          end else begin
            if (ptr_q == 2'd3) led_d = shift_q;
            ptr_d = ptr_q + 2'd1;
          end
        end
      end
      S_WR_ACK: begin
        if (scl_fall) begin
          sda_out_d = 1'b1;
          bitcnt_d  = 4'd0;
          state_d   = S_WR_DATA;
        end
      end
      S_RD_DATA: begin
        if (scl_fall) begin
          if (bitcnt_q == 4'd7) begin
            sda_out_d = 1'b1;
            ptr_d     = ptr_q + 2'd1;
            acked_d   = 1'b0;
            state_d   = S_RD_ACK;
          end else begin
            sda_out_d = tx_q[6];
            tx_d      = {tx_q[6:0], 1'b0};
            bitcnt_d  = bitcnt_q + 4'd1;
          end
        end
      end
      S_RD_ACK: begin
        if (scl_rise) begin
          if (sda_s) state_d = S_IGNORE;
          else       acked_d = 1'b1;
        end else if (scl_fall && acked_q) begin
          tx_d      = reg_byte(ptr_q, snap_btn_q, snap_led_q);
          sda_out_d = tx_d[7];
          bitcnt_d  = 4'd0;
          state_d   = S_RD_DATA;
        end
      end
      S_IGNORE: sda_out_d = 1'b1;
      default:  ;
    endcase

    // Bus conditions take precedence over whatever the state machine decided
    if (start_det) begin
      state_d   = S_ADDR;
      bitcnt_d  = 4'd0;
      sda_out_d = 1'b1;
      busy_d    = 1'b0;
    end else if (stop_det) begin
      state_d   = S_IDLE;
      sda_out_d = 1'b1;
      busy_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      sda_out_q  <= 1'b1;
      busy_q     <= 1'b0;
      led_q      <= '0;
      ptr_q      <= '0;
      first_q    <= 1'b0;
      rw_q       <= 1'b0;
      acked_q    <= 1'b0;
      snap_btn_q <= '0;
      snap_led_q <= '0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      sda_out_q  <= sda_out_d;
      busy_q     <= busy_d;
      led_q      <= led_d;
      ptr_q      <= ptr_d;
      first_q    <= first_d;
      rw_q       <= rw_d;
      acked_q    <= acked_d;
      snap_btn_q <= snap_btn_d;
      snap_led_q <= snap_led_d;
    end
  end

  assign sda_out = sda_out_q;
  assign led     = led_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_joypad_i2c_target.sv
// Bench for joypad_i2c_target: a bit-banged I2C controller drives the bus, a
// register-level reference model supplies expectations, a monitor scores them.
module tb_joypad_i2c_target;

  localparam logic [6:0] TADDR = 7'h52;
  localparam logic [7:0] DEVID = 8'hA5;
  localparam int Q = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_out;
  logic        sda_line;
  logic [15:0] buttons = '0;
  logic [7:0]  led;
  logic        busy;

  assign sda_line = sda_m & sda_out;

  always #5 clk = ~clk;

  joypad_i2c_target #(.ADDR(7'h52), .DEVICE_ID(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl), .sda_in(sda_line), .sda_out(sda_out),
    .buttons(buttons), .led(led), .busy(busy)
  );

  typedef struct {
    string       name;
    logic [31:0] val;
  } item_t;

  item_t exp_q[$];
  item_t obs_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  // Reference model: register file contents, pointer and transaction flags
  int         m_ptr = 0;
  logic [7:0] m_led = '0;
  logic [7:0] m_snap[4];
  bit         m_sel = 0, m_first = 0, m_busy = 0;

  task automatic push(input string name, input logic [31:0] e, input logic [31:0] o);
    exp_q.push_back('{name, e});
    obs_q.push_back('{name, o});
  endtask

  initial begin : monitor
    item_t e, o;
    forever begin
      wait (obs_q.size() != 0);
      o = obs_q.pop_front();
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL %s: got %0h, no expectation queued", o.name, o.val);
      end else begin
        e = exp_q.pop_front();
        if (o.val !== e.val || o.name != e.name) begin
          miscompares++;
          $display("FAIL %s: got %0h, expected %0h", o.name, o.val, e.val);
        end
      end
    end
  end

  task automatic clk_bit(input logic b, output logic r);
    sda_m = b;
    #(Q) scl = 1'b1;
    #(Q) r = sda_line;
    #(Q) scl = 1'b0;
    #(Q);
  endtask

  task automatic do_start();
    sda_m = 1'b1;
    #(Q) scl = 1'b1;
    #(Q) sda_m = 1'b0;
    #(Q) scl = 1'b0;
    #(Q);
    m_sel = 0; m_busy = 0;
  endtask

  task automatic do_stop();
    sda_m = 1'b0;
    #(Q) scl = 1'b1;
    #(Q) sda_m = 1'b1;
    #(Q);
    m_sel = 0; m_busy = 0;
    push("busy_stop", 32'(m_busy), 32'(busy));
  endtask

  task automatic do_addr(input logic [6:0] a, input logic rw);
    logic [7:0] d;
    logic r;
    d = {a, rw};
    for (int i = 7; i >= 0; i--) clk_bit(d[i], r);
    clk_bit(1'b1, r);
    m_sel   = (a == TADDR);
    m_busy  = m_sel;
    m_first = !rw;
    if (m_sel && rw) begin
      m_snap[0] = buttons[7:0];
      m_snap[1] = buttons[15:8];
      m_snap[2] = DEVID;
      m_snap[3] = m_led;
    end
    push("addr_ack", m_sel ? 32'd0 : 32'd1, 32'(r));
    push("busy_addr", 32'(m_busy), 32'(busy));
  endtask

  task automatic do_wbyte(input logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], r);
    clk_bit(1'b1, r);
    if (m_sel) begin
      if (m_first) begin
        m_ptr   = int'(d[1:0]);
        m_first = 0;
      end else begin
        if (m_ptr == 3) m_led = d;
        m_ptr = (m_ptr + 1) % 4;
      end
    end
    push("wr_ack", m_sel ? 32'd0 : 32'd1, 32'(r));
    push("led", 32'(m_led), 32'(led));
    push("busy_wr", 32'(m_busy), 32'(busy));
  endtask

  task automatic do_rbyte(input logic nack);
    logic [7:0] v;
    logic       r;
    logic [7:0] e;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, r);
      v[i] = r;
    end
    clk_bit(nack, r);
    e = m_sel ? m_snap[m_ptr] : 8'hFF;
    if (m_sel) m_ptr = (m_ptr + 1) % 4;
    push("rd_data", 32'(e), 32'(v));
    if (nack) begin
      m_sel = 0;
      push("sda_rel", 32'd1, 32'(sda_out));
    end
  endtask

  initial begin : watchdog
    #(3_000_000);
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin : stim
    logic       r;
    logic [6:0] a;
    int         n, op;

    repeat (4) @(negedge clk);
    push("rst_sda", 32'd1, 32'(sda_out));
    push("rst_led", 32'd0, 32'(led));
    push("rst_busy", 32'd0, 32'(busy));
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Pointer 3 then LED value
    do_start(); do_addr(TADDR, 1'b0); do_wbyte(8'h03); do_wbyte(8'h5A); do_stop();

    // Pointer 0, repeated START, read all four registers
    buttons = 16'hBEEF;
    do_start(); do_addr(TADDR, 1'b0); do_wbyte(8'h00);
    do_start(); do_addr(TADDR, 1'b1);
    do_rbyte(1'b0); do_rbyte(1'b0); do_rbyte(1'b0); do_rbyte(1'b1);
    do_stop();

    // Wrong address: nothing acknowledged, LED untouched
    do_start(); do_addr(7'h53, 1'b0); do_wbyte(8'h03); do_wbyte(8'h11); do_stop();

    // Read wrapping from pointer 3 while buttons change mid-burst
    do_start(); do_addr(TADDR, 1'b0); do_wbyte(8'h03);
    do_start(); do_addr(TADDR, 1'b1);
    do_rbyte(1'b0); buttons = 16'h0000; do_rbyte(1'b0); do_rbyte(1'b1);
    do_stop();

    // Pointer survives STOP
    buttons = 16'hBEEF;
    do_start(); do_addr(TADDR, 1'b0); do_wbyte(8'h03); do_stop();
    do_start(); do_addr(TADDR, 1'b1); do_rbyte(1'b1); do_stop();

    // Reset while the target is driving a 0 data bit (bit 6 of 0xA5)
    do_start(); do_addr(TADDR, 1'b0); do_wbyte(8'h02);
    do_start(); do_addr(TADDR, 1'b1);
    clk_bit(1'b1, r);
    push("rd_bit7", 32'd1, 32'(r));
    push("drive0", 32'd0, 32'(sda_out));
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk);
    push("mid_rst_sda", 32'd1, 32'(sda_out));
    push("mid_rst_led", 32'd0, 32'(led));
    push("mid_rst_busy", 32'd0, 32'(busy));
    rst_n = 1'b1;
    m_ptr = 0; m_led = '0; m_sel = 0; m_busy = 0; m_first = 0;
    do_start(); do_addr(TADDR, 1'b0); do_wbyte(8'h01); do_stop();

    // Randomized transactions
    repeat (12) begin
      buttons = 16'($urandom);
      op = int'($urandom_range(0, 2));
      case (op)
        0: begin
          do_start(); do_addr(TADDR, 1'b0); do_wbyte(8'($urandom));
          n = int'($urandom_range(0, 3));
          for (int i = 0; i < n; i++) do_wbyte(8'($urandom));
          do_stop();
        end
        1: begin
          a = ($urandom_range(0, 5) == 0) ? (TADDR ^ (7'd1 << $urandom_range(0, 6))) : TADDR;
          do_start(); do_addr(a, 1'b1);
          n = int'($urandom_range(1, 4));
          for (int i = 0; i < n; i++) do_rbyte(i == n - 1);
          do_stop();
        end
        default: begin
          do_start(); do_addr(TADDR, 1'b0); do_wbyte(8'($urandom));
          do_start(); do_addr(TADDR, 1'b1);
          n = int'($urandom_range(1, 4));
          for (int i = 0; i < n; i++) do_rbyte(i == n - 1);
          do_stop();
        end
      endcase
    end

    for (int i = 0; i < 100 && obs_q.size() != 0; i++) #10;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending observations, expected 0 (%0d expectations left)",
               obs_q.size(), exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
